// File: rtl/game_packet_tx.sv
// game_packet_tx: sends a 96-bit player packet as a 14-byte 8N1 serial frame
// (A5 sync, 12 payload bytes LSB first, XOR checksum) with a one-deep latest-wins queue.
module game_packet_tx #(
    parameter int CLKS_PER_BIT = 644,
    parameter int GAP_BITS     = 2
) (
    input  logic        clk_pixel_in,
    input  logic        rst_n_in,
    input  logic [88:0] data_in,
    input  logic        scored_in,
    input  logic        data_in_valid,
    output logic        tx_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic        overwrite_out
);

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [3:0]  LAST_BYTE = 4'd13;
    localparam logic [10:0] BIT_LAST  = 11'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  GAP_LAST  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t      state_q, state_nx;
    logic [10:0] clk_cnt_q, clk_cnt_nx;
    logic [2:0]  bit_idx_q, bit_idx_nx;
    logic [3:0]  byte_idx_q, byte_idx_nx;
    logic [3:0]  gap_cnt_q, gap_cnt_nx;
    logic        pend_vld_q;
    logic [95:0] pend_data_q;
    logic [95:0] frame_sr_q;
    logic [7:0]  cur_byte_q;
    logic [7:0]  csum_q;
    logic        tx_q, tx_nx;
    logic        overwrite_q;
    logic [95:0] payload;
    logic        bit_end, frame_end, start_frame, start_from_pend, load_byte;

    assign payload = {6'b0, scored_in, data_in};

    // A new frame may begin from IDLE or directly at the end of the previous frame's gap.
    always_comb begin
        bit_end = (clk_cnt_q == BIT_LAST);
        if (GAP_BITS == 0)
            frame_end = (state_q == STOP) && (byte_idx_q == LAST_BYTE) && bit_end;
        else
            frame_end = (state_q == GAP) && (gap_cnt_q == GAP_LAST) && bit_end;
        start_frame     = ((state_q == IDLE) || frame_end) && (pend_vld_q || data_in_valid);
        start_from_pend = start_frame && pend_vld_q;
    end

    always_comb begin
        state_nx    = state_q;
        clk_cnt_nx  = bit_end ? 11'd0 : clk_cnt_q + 11'd1;
        bit_idx_nx  = bit_idx_q;
        byte_idx_nx = byte_idx_q;
        gap_cnt_nx  = gap_cnt_q;
        load_byte   = 1'b0;
        tx_nx       = 1'b1;
        case (state_q)
            IDLE: begin
                clk_cnt_nx = 11'd0;
                if (start_frame) begin
                    state_nx    = START;
                    byte_idx_nx = 4'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx   = DATA;
                    bit_idx_nx = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7)
                        state_nx = STOP;
                    else
                        bit_idx_nx = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        state_nx    = START;
                        byte_idx_nx = byte_idx_q + 4'd1;
                        load_byte   = 1'b1;
                    end else if (GAP_BITS > 0) begin
                        state_nx   = GAP;
                        gap_cnt_nx = 4'd0;
                    end else if (start_frame) begin
                        state_nx    = START;
                        byte_idx_nx = 4'd0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        if (start_frame) begin
                            state_nx    = START;
                            byte_idx_nx = 4'd0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        gap_cnt_nx = gap_cnt_q + 4'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // The line level is decided from the state being entered so it is registered without extra latency.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = cur_byte_q[bit_idx_nx];
            default: tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            clk_cnt_q   <= 11'd0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 4'd0;
            gap_cnt_q   <= 4'd0;
            pend_vld_q  <= 1'b0;
            tx_q        <= 1'b1;
            overwrite_q <= 1'b0;
        end else begin
            state_q     <= state_nx;
            clk_cnt_q   <= clk_cnt_nx;
            bit_idx_q   <= bit_idx_nx;
            byte_idx_q  <= byte_idx_nx;
            gap_cnt_q   <= gap_cnt_nx;
            tx_q        <= tx_nx;
            overwrite_q <= data_in_valid && pend_vld_q && !start_frame;
            if (start_frame)
                pend_vld_q <= start_from_pend && data_in_valid;
            else if (data_in_valid)
                pend_vld_q <= 1'b1;
        end
    end

    // Payload bytes are peeled off a private copy, so later data_in changes cannot leak in.
    always_ff @(posedge clk_pixel_in) begin
        if (data_in_valid)
            pend_data_q <= payload;
        if (start_frame) begin
            frame_sr_q <= start_from_pend ? pend_data_q : payload;
            cur_byte_q <= SYNC_BYTE;
            csum_q     <= 8'd0;
        end else if (load_byte) begin
            if (byte_idx_nx == LAST_BYTE) begin
                cur_byte_q <= csum_q;
            end else begin
                cur_byte_q <= frame_sr_q[7:0];
                csum_q     <= csum_q ^ frame_sr_q[7:0];
                frame_sr_q <= frame_sr_q >> 8;
            end
        end
    end

    assign tx_out         = tx_q;
    assign busy_out       = (state_q != IDLE);
    assign frame_done_out = (state_q == STOP) && (byte_idx_q == LAST_BYTE) && bit_end;
    assign overwrite_out  = overwrite_q;

endmodule

// File: tb/tb_game_packet_tx.sv
// tb_game_packet_tx: randomized bench for game_packet_tx with a frame-timing reference
// model and a mid-bit sampling serial decoder.
module tb_game_packet_tx;
    localparam int CPB       = 4;
    localparam int GAP       = 2;
    localparam int FRAME_CYC = 140 * CPB;
    localparam int SLOT      = FRAME_CYC + GAP * CPB;

    logic        clk_pixel_in = 1'b0;
    logic        rst_n_in     = 1'b0;
    logic [88:0] data_in      = '0;
    logic        scored_in    = 1'b0;
    logic        data_in_valid = 1'b0;
    logic        tx_out, busy_out, frame_done_out, overwrite_out;

    always #5 clk_pixel_in = ~clk_pixel_in;

    game_packet_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
        .clk_pixel_in  (clk_pixel_in),
        .rst_n_in      (rst_n_in),
        .data_in       (data_in),
        .scored_in     (scored_in),
        .data_in_valid (data_in_valid),
        .tx_out        (tx_out),
        .busy_out      (busy_out),
        .frame_done_out(frame_done_out),
        .overwrite_out (overwrite_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // reference model: at most one frame on the line plus one pending packet
    bit           in_rst = 1'b1;
    bit           m_active = 1'b0;
    int           m_s = 0;
    logic [111:0] m_frame = '0;
    bit           m_pend = 1'b0;
    logic [95:0]  m_pend_p = '0;
    bit           m_ovw = 1'b0;
    logic [111:0] exp_q[$];

    // decoder and observed events
    bit           prev_tx = 1'b1;
    bit           dec_active = 1'b0;
    int           dec_start = 0;
    logic [111:0] dec_frame = '0;
    logic [111:0] last_frame = '0;
    int           last_start = 0;
    int           last_done = 0;
    int           start_gap = 0;
    int           ovw_seen = 0;
    int           busy_low = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [111:0] frame_of(input logic [95:0] p);
        logic [111:0] f;
        logic [7:0]   x;
        x = 8'h00;
        f = '0;
        f[7:0] = 8'hA5;
        for (int k = 1; k <= 12; k++) begin
            f[8*k +: 8] = p[8*(k-1) +: 8];
            x = x ^ p[8*(k-1) +: 8];
        end
        f[111:104] = x;
        return f;
    endfunction

    function automatic logic [88:0] rnd89();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[88:0];
    endfunction

    task automatic model_start(input logic [95:0] p);
        m_active = 1'b1;
        m_s      = cyc_n + 1;
        m_frame  = frame_of(p);
        exp_q.push_back(m_frame);
    endtask

    task automatic model_step(input bit v, input logic [95:0] p);
        int e;
        m_ovw = 1'b0;
        if (in_rst) return;
        e = m_s + SLOT - 1;
        if (m_active && cyc_n == e) begin
            if (m_pend) begin
                model_start(m_pend_p);
                m_pend = v;
                if (v) m_pend_p = p;
            end else if (v) begin
                model_start(p);
            end else begin
                m_active = 1'b0;
            end
        end else if (m_active) begin
            if (v) begin
                if (m_pend) m_ovw = 1'b1;
                m_pend   = 1'b1;
                m_pend_p = p;
            end
        end else if (v) begin
            model_start(p);
        end
    endtask

    task automatic check_cycle();
        int   off, bp, bi, b;
        logic exp_tx, exp_busy, exp_done;
        exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
        if (m_active) begin
            off = cyc_n - m_s;
            exp_busy = 1'b1;
            if (off < FRAME_CYC) begin
                bp = off / CPB; bi = bp / 10; b = bp % 10;
                if (b == 0)      exp_tx = 1'b0;
                else if (b == 9) exp_tx = 1'b1;
                else             exp_tx = m_frame[8*bi + b - 1];
                exp_done = (off == FRAME_CYC - 1);
            end
        end
        chk("tx_out", tx_out, exp_tx);
        chk("busy_out", busy_out, exp_busy);
        chk("frame_done_out", frame_done_out, exp_done);
        chk("overwrite_out", overwrite_out, m_ovw);

        if (!busy_out) busy_low++;
        if (frame_done_out) last_done = cyc_n;
        if (overwrite_out) ovw_seen++;
        if (!dec_active && prev_tx && !tx_out) begin
            dec_active = 1'b1;
            dec_start  = cyc_n;
            start_gap  = cyc_n - last_done;
            last_start = cyc_n;
        end
        if (dec_active) begin
            off = cyc_n - dec_start;
            if (off % CPB == CPB / 2) begin
                bp = off / CPB; bi = bp / 10; b = bp % 10;
                if (b >= 1 && b <= 8) begin
                    dec_frame[8*bi + b - 1] = tx_out;
                end else if (b == 9 && bi == 13) begin
                    last_frame = dec_frame;
                    dec_active = 1'b0;
                    if (exp_q.size() == 0) chk("dec_unexpected_frame", 1, 0);
                    else                   chk("dec_frame", dec_frame, exp_q.pop_front());
                end
            end
        end
        prev_tx = tx_out;
    endtask

    task automatic cycle_in(input bit v, input logic [88:0] d, input bit s);
        data_in_valid = v;
        data_in       = d;
        scored_in     = s;
        model_step(v, {6'b0, s, d});
        @(posedge clk_pixel_in);
        cyc_n++;
        @(negedge clk_pixel_in);
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_in(1'b0, rnd89(), 1'($urandom_range(0, 1)));
    endtask

    task automatic assert_rst();
        rst_n_in   = 1'b0;
        in_rst     = 1'b1;
        m_active   = 1'b0;
        m_pend     = 1'b0;
        m_ovw      = 1'b0;
        exp_q.delete();
        dec_active = 1'b0;
        prev_tx    = 1'b1;
        #1;
        chk("rst_async_tx", tx_out, 1'b1);
        chk("rst_async_busy", busy_out, 1'b0);
        chk("rst_async_done", frame_done_out, 1'b0);
        chk("rst_async_ovw", overwrite_out, 1'b0);
    endtask

    task automatic release_rst();
        rst_n_in = 1'b1;
        in_rst   = 1'b0;
    endtask

    initial begin
        logic [111:0] exp27, exp28;
        logic [88:0]  pc;
        bit           sc;
        int           v_cyc, gap_end;
        exp27 = {8'h02, 8'h02, 88'h0, 8'hA5};
        exp28 = {8'hFC, 8'h03, {11{8'hFF}}, 8'hA5};

        @(negedge clk_pixel_in);
        check_cycle();
        // strobes while held in reset must be ignored
        for (int i = 0; i < 3; i++) cycle_in(1'b1, rnd89(), 1'b1);
        release_rst();

        // zero data with scored flag
        v_cyc = cyc_n;
        cycle_in(1'b1, '0, 1'b1);
        idle(SLOT + 5);
        chk("r27_frame", last_frame, exp27);
        chk("r27_latency", last_start - v_cyc, 1);
        chk("r27_done_cycle", last_done - last_start + 1, FRAME_CYC);

        // all-ones data
        cycle_in(1'b1, {89{1'b1}}, 1'b1);
        idle(SLOT + 5);
        chk("r28_frame", last_frame, exp28);

        // three strobes during one frame: one overwrite, third packet wins
        ovw_seen = 0;
        cycle_in(1'b1, rnd89(), 1'b0);
        idle(50);
        cycle_in(1'b1, rnd89(), 1'b1);
        idle(100);
        pc = rnd89(); sc = 1'b0;
        cycle_in(1'b1, pc, sc);
        idle(2 * SLOT);
        chk("r29_overwrites", ovw_seen, 1);
        chk("r29_second_frame", last_frame, frame_of({6'b0, sc, pc}));
        chk("r29_gap_to_start", start_gap, GAP * CPB + 1);

        // strobe on the final gap cycle
        v_cyc = cyc_n;
        cycle_in(1'b1, rnd89(), 1'b1);
        idle(SLOT - 1);
        gap_end  = cyc_n;
        busy_low = 0;
        cycle_in(1'b1, rnd89(), 1'b0);
        idle(20);
        chk("r30_start", last_start, gap_end + 1);
        chk("r30_busy_continuous", busy_low, 0);
        idle(SLOT);

        // reset during the start bit of byte 5, then a fresh frame
        cycle_in(1'b1, rnd89(), 1'b1);
        idle(5 * 10 * CPB + 1);
        chk("r31_pre_tx_low", tx_out, 1'b0);
        assert_rst();
        for (int i = 0; i < 3; i++) cycle_in(1'b1, rnd89(), 1'b0);
        release_rst();
        pc = rnd89(); sc = 1'b1;
        cycle_in(1'b1, pc, sc);
        idle(SLOT + 5);
        chk("r31_sync", last_frame[7:0], 8'hA5);
        chk("r31_frame", last_frame, frame_of({6'b0, sc, pc}));

        // randomized traffic
        for (int i = 0; i < 8; i++) begin
            cycle_in(1'b1, rnd89(), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 700));
        end
        idle(2 * SLOT + 10);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_idle", busy_out, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
